// File: rtl/qrs_search_scheduler_if.sv
// Signal bundle between the algorithm FSM / extremum finder (master) and the
// QRS search scheduler (slave).
interface qrs_search_scheduler_if #(
    parameter int DATA_WIDTH = 11,
    parameter int MISS_WIDTH = 8
);
    logic                  i_ce;
    logic                  i_search_en;
    logic [DATA_WIDTH-1:0] i_rr_period;
    logic                  i_rr_period_updated;
    logic [DATA_WIDTH-1:0] i_qrs_threshold;
    logic                  i_extremum_found;

    logic                  o_window_open;
    logic                  o_refractory;
    logic [DATA_WIDTH-1:0] o_threshold_eff;
    logic                  o_searchback;
    logic                  o_beat_accepted;
    logic                  o_beat_from_sb;
    logic [MISS_WIDTH-1:0] o_missed_beats;

    modport master (
        output i_ce, i_search_en, i_rr_period, i_rr_period_updated,
               i_qrs_threshold, i_extremum_found,
        input  o_window_open, o_refractory, o_threshold_eff, o_searchback,
               o_beat_accepted, o_beat_from_sb, o_missed_beats
    );

    modport slave (
        input  i_ce, i_search_en, i_rr_period, i_rr_period_updated,
               i_qrs_threshold, i_extremum_found,
        output o_window_open, o_refractory, o_threshold_eff, o_searchback,
               o_beat_accepted, o_beat_from_sb, o_missed_beats
    );
endinterface

// File: rtl/qrs_search_scheduler.sv
// QRS search scheduler: gates the extremum finder window/threshold, enforces
// refractory, times out a window at 1.625 x RR and retries at half threshold.
module qrs_search_scheduler #(
    parameter int DATA_WIDTH = 11,
    parameter int REFRACTORY = 72,
    parameter int DEFAULT_RR = 360,
    parameter int MISS_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    qrs_search_scheduler_if.slave bus
);
    localparam int CW = DATA_WIDTH + 1;
    localparam logic [CW-1:0]         CNT_MAX   = '1;
    localparam logic [CW-1:0]         REFR_LAST = CW'(REFRACTORY - 1);
    localparam logic [DATA_WIDTH-1:0] RR_RESET  = DATA_WIDTH'(DEFAULT_RR);
    localparam logic [MISS_WIDTH-1:0] MISS_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_SEARCHBACK,
        S_REFRACT
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rr_lat_q, rr_lat_d;
    logic [MISS_WIDTH-1:0] miss_q, miss_d;
    logic                  sb_pulse_q, sb_pulse_d;
    logic                  beat_q, beat_d;
    logic                  beat_sb_q, beat_sb_d;

    logic [CW-1:0] tmo;
    logic          tmo_hit;

    // 1.625 x RR, kept one bit wider so the sum never wraps.
    assign tmo     = {1'b0, rr_lat_q} + CW'(rr_lat_q >> 1) + CW'(rr_lat_q >> 3);
    assign tmo_hit = bus.i_ce && (cnt_q >= (tmo - CW'(1)));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rr_lat_q   <= RR_RESET;
            miss_q     <= '0;
            sb_pulse_q <= 1'b0;
            beat_q     <= 1'b0;
            beat_sb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_lat_q   <= rr_lat_d;
            miss_q     <= miss_d;
            sb_pulse_q <= sb_pulse_d;
            beat_q     <= beat_d;
            beat_sb_q  <= beat_sb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        miss_d     = miss_q;
        sb_pulse_d = 1'b0;
        beat_d     = 1'b0;
        beat_sb_d  = 1'b0;
        rr_lat_d   = rr_lat_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_search_en) state_d = S_SEARCH;
            end
            S_SEARCH, S_SEARCHBACK: begin
                // Enable drop outranks a peak, and a peak outranks the timeout.
                if (!bus.i_search_en) begin
                    state_d = S_IDLE;
                end else if (bus.i_extremum_found) begin
                    state_d   = S_REFRACT;
                    beat_d    = 1'b1;
                    beat_sb_d = (state_q == S_SEARCHBACK);
                end else if (tmo_hit) begin
                    if (state_q == S_SEARCH) begin
                        state_d    = S_SEARCHBACK;
                        sb_pulse_d = 1'b1;
                        if (miss_q != MISS_MAX) miss_d = miss_q + MISS_WIDTH'(1);
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
            end
            S_REFRACT: begin
                if (bus.i_ce && (cnt_q == REFR_LAST))
                    state_d = bus.i_search_en ? S_SEARCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (bus.i_ce && (state_q != S_IDLE) && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CW'(1);
        else
            cnt_d = cnt_q;

        if (bus.i_rr_period_updated && (bus.i_rr_period != '0))
            rr_lat_d = bus.i_rr_period;
    end

    always_comb begin
        bus.o_window_open   = (state_q == S_SEARCH) || (state_q == S_SEARCHBACK);
        bus.o_refractory    = (state_q == S_REFRACT);
        bus.o_searchback    = sb_pulse_q;
        bus.o_beat_accepted = beat_q;
        bus.o_beat_from_sb  = beat_sb_q;
        bus.o_missed_beats  = miss_q;
        unique case (state_q)
            S_SEARCHBACK:       bus.o_threshold_eff = bus.i_qrs_threshold >> 1;
            S_SEARCH, S_REFRACT: bus.o_threshold_eff = bus.i_qrs_threshold;
            default:            bus.o_threshold_eff = '0;
        endcase
    end
endmodule

// File: tb/tb_qrs_search_scheduler.sv
// Bench for qrs_search_scheduler: vector table, directed timing sequences and
// randomized traffic compared against a phase/elapsed-sample reference model.
module tb_qrs_search_scheduler;
    localparam int DW     = 11;
    localparam int MW     = 8;
    localparam int REFR   = 72;
    localparam int DEF_RR = 360;

    localparam int M_IDLE  = 0;
    localparam int M_HUNT  = 1;
    localparam int M_BACK  = 2;
    localparam int M_QUIET = 3;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    qrs_search_scheduler_if #(.DATA_WIDTH(DW), .MISS_WIDTH(MW)) bus ();

    qrs_search_scheduler #(
        .DATA_WIDTH(DW),
        .REFRACTORY(REFR),
        .DEFAULT_RR(DEF_RR),
        .MISS_WIDTH(MW)
    ) dut (
        .i_clk (clk),
        .i_nrst(nrst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_mode, m_elapsed, m_rr, m_miss;
    bit m_sbp, m_beat, m_fsb;

    typedef struct {
        bit ce;
        bit en;
        bit ext;
        int thr;
        bit e_win;
        bit e_ref;
        int e_thr;
        bit e_beat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_obs();
        return {bus.o_window_open, bus.o_refractory, bus.o_threshold_eff,
                bus.o_searchback, bus.o_beat_accepted, bus.o_beat_from_sb,
                bus.o_missed_beats};
    endfunction

    function automatic logic [23:0] model_obs();
        logic          w, r;
        logic [DW-1:0] t;
        w = (m_mode == M_HUNT) || (m_mode == M_BACK);
        r = (m_mode == M_QUIET);
        if (m_mode == M_BACK) t = bus.i_qrs_threshold >> 1;
        else if (w || r)      t = bus.i_qrs_threshold;
        else                  t = '0;
        return {w, r, t, m_sbp, m_beat, m_fsb, 8'(m_miss)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_elapsed = 0; m_rr = DEF_RR; m_miss = 0;
        m_sbp = 0; m_beat = 0; m_fsb = 0;
    endtask

    // A phase ends once the samples spent in it reach its length.
    task automatic model_step();
        int limit;
        int nxt;
        bit ce, en, ext;
        limit = m_rr + m_rr / 2 + m_rr / 8;
        nxt = m_mode;
        ce = bus.i_ce; en = bus.i_search_en; ext = bus.i_extremum_found;
        m_sbp = 0; m_beat = 0; m_fsb = 0;
        case (m_mode)
            M_IDLE: if (en) nxt = M_HUNT;
            M_HUNT, M_BACK: begin
                if (!en) nxt = M_IDLE;
                else if (ext) begin
                    nxt = M_QUIET; m_beat = 1; m_fsb = (m_mode == M_BACK);
                end else if (ce && (m_elapsed + 1 >= limit)) begin
                    if (m_mode == M_HUNT) begin
                        nxt = M_BACK; m_sbp = 1;
                        if (m_miss < 255) m_miss++;
                    end else nxt = M_HUNT;
                end
            end
            M_QUIET: if (ce && (m_elapsed + 1 == REFR)) nxt = en ? M_HUNT : M_IDLE;
            default: nxt = M_IDLE;
        endcase
        if (nxt != m_mode) m_elapsed = 0;
        else if (ce && m_mode != M_IDLE) m_elapsed++;
        if (bus.i_rr_period_updated && bus.i_rr_period != 0) m_rr = bus.i_rr_period;
        m_mode = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (nrst) model_step();
        @(negedge clk);
        chk("model", dut_obs(), model_obs());
        bus.i_extremum_found    = 1'b0;
        bus.i_rr_period_updated = 1'b0;
    endtask

    task automatic run_until_sb(output int n);
        n = 0;
        do begin tick(); n++; end while (!bus.o_searchback && n < 5000);
    endtask

    task automatic count_refract(output int n);
        n = 0;
        while (bus.o_refractory && n < 500) begin tick(); n++; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        int n, sbc;
        nrst = 1'b0;
        bus.i_ce = 0; bus.i_search_en = 0; bus.i_rr_period = '0;
        bus.i_rr_period_updated = 0; bus.i_qrs_threshold = '0; bus.i_extremum_found = 0;
        model_reset();

        for (int i = 0; i < 6; i++) begin
            bus.i_ce = 1'($urandom); bus.i_search_en = 1'($urandom);
            bus.i_rr_period = DW'($urandom); bus.i_rr_period_updated = 1'($urandom);
            bus.i_qrs_threshold = DW'($urandom); bus.i_extremum_found = 1'($urandom);
            @(negedge clk);
            chk("rst_outs", dut_obs(), 24'h0);
        end
        bus.i_rr_period_updated = 0; bus.i_extremum_found = 0; bus.i_rr_period = '0;
        nrst = 1'b1;

        tbl[0] = '{1, 0, 1, 400, 0, 0, 0,   0};
        tbl[1] = '{1, 1, 0, 400, 1, 0, 400, 0};
        tbl[2] = '{1, 0, 1, 400, 0, 0, 0,   0};
        tbl[3] = '{0, 1, 0, 500, 1, 0, 500, 0};
        tbl[4] = '{0, 1, 1, 500, 0, 1, 500, 1};
        tbl[5] = '{0, 1, 0, 500, 0, 1, 500, 0};
        tbl[6] = '{1, 0, 1, 600, 0, 1, 600, 0};
        tbl[7] = '{1, 0, 0, 600, 0, 1, 600, 0};
        for (int i = 0; i < 8; i++) begin
            bus.i_ce = tbl[i].ce; bus.i_search_en = tbl[i].en;
            bus.i_extremum_found = tbl[i].ext; bus.i_qrs_threshold = DW'(tbl[i].thr);
            tick();
            chk($sformatf("vec%0d", i), dut_obs(),
                {tbl[i].e_win, tbl[i].e_ref, DW'(tbl[i].e_thr), 1'b0, tbl[i].e_beat, 1'b0, 8'd0});
        end
        // Enable dropped during refractory: 2 samples counted, 70 remain.
        count_refract(n);
        chk("refr_drop_len", n, 70);
        chk("refr_drop_idle", {bus.o_window_open, bus.o_threshold_eff}, 0);

        bus.i_ce = 1; bus.i_search_en = 1; bus.i_qrs_threshold = 400;
        tick();
        repeat (100) tick();
        bus.i_extremum_found = 1; tick();
        chk("beat_search", {bus.o_beat_accepted, bus.o_beat_from_sb}, 2'b10);
        repeat (29) tick();
        bus.i_extremum_found = 1; tick();
        chk("refr_ext_ignored", bus.o_beat_accepted, 0);
        count_refract(n);
        chk("refr_len", 30 + n, REFR);
        chk("reopen", {bus.o_window_open, bus.o_threshold_eff}, {1'b1, 11'd400});

        run_until_sb(n);
        chk("sb_lat_default", n, 585);
        chk("sb_thr_half", bus.o_threshold_eff, 200);
        chk("miss_1", bus.o_missed_beats, 1);
        repeat (49) tick();
        bus.i_extremum_found = 1; tick();
        chk("beat_sb", {bus.o_beat_accepted, bus.o_beat_from_sb}, 2'b11);
        bus.i_rr_period = 200; bus.i_rr_period_updated = 1; tick();
        count_refract(n);
        chk("refr_len_sb", n, 71);
        run_until_sb(n);
        chk("sb_lat_200", n, 325);
        bus.i_rr_period = 0; bus.i_rr_period_updated = 1; tick();
        n = 1;
        while (bus.o_threshold_eff != 400 && n < 2000) begin tick(); n++; end
        chk("giveup_len", n, 325);
        chk("giveup_no_count", bus.o_missed_beats, 2);
        run_until_sb(n);
        chk("sb_lat_after_zero", n, 325);

        do_reset();
        bus.i_ce = 1; bus.i_search_en = 1;
        tick();
        repeat (400) tick();
        bus.i_rr_period = 100; bus.i_rr_period_updated = 1; tick();
        chk("shrink_no_early", bus.o_searchback, 0);
        tick();
        chk("shrink_fire", bus.o_searchback, 1);

        do_reset();
        bus.i_rr_period = 1; bus.i_rr_period_updated = 1; tick();
        sbc = 0;
        for (int i = 0; i < 600; i++) begin tick(); if (bus.o_searchback) sbc++; end
        chk("sb_count_300", sbc, 300);
        chk("miss_sat", bus.o_missed_beats, 255);
        tick();
        chk("in_sb_before_rst", bus.o_searchback, 1);
        #2 nrst = 1'b0;
        #1 chk("async_rst", dut_obs(), 24'h0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            bus.i_ce = ($urandom % 4) != 0;
            bus.i_search_en = ($urandom % 32) != 0;
            bus.i_extremum_found = ($urandom % 64) == 0;
            bus.i_rr_period = DW'($urandom_range(0, 400));
            bus.i_rr_period_updated = ($urandom % 50) == 0;
            bus.i_qrs_threshold = DW'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
